// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a two-flop line synchroniser and a small
// first-word-fall-through FIFO drained by a valid/ready handshake.
module uart_rx_fifo #(
    parameter int DIVISOR    = 52,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_rx,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  overrun,
    output logic                  framing_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(DIVISOR);

    localparam logic [CW-1:0] FULL_BIT = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(DIVISOR / 2 - 1);
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic                  r_rx_meta;
    logic                  r_rx_s;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_push;
    logic                  r_fe;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovr;

    logic w_cnt_zero;
    logic w_pop;
    logic w_full;
    logic w_push;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= serial_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= FULL_BIT;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_push    <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_push <= 1'b0;
            r_fe   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Half-bit load puts every later sample at mid-bit.
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= HALF_BIT;
                    end
                end
                S_START: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= FULL_BIT;
                    end else begin
                        r_state   <= S_DATA;
                        r_bit_idx <= 3'd0;
                        r_cnt     <= FULL_BIT;
                    end
                end
                S_DATA: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_cnt     <= FULL_BIT;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= FULL_BIT;
                        if (r_rx_s) begin
                            r_push  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_fe    <= 1'b1;
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= FULL_BIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= FULL_BIT;
                end
            endcase
        end
    end

    assign w_pop  = rx_valid & rx_ready;
    assign w_full = (r_count == FULL);
    assign w_push = r_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= r_push & ~w_push;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign rx_valid      = (r_count != '0);
    assign rx_data       = r_mem[r_rd_ptr];
    assign rx_count      = r_count;
    assign overrun       = r_ovr;
    assign framing_error = r_fe;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frame scenarios plus a randomized
// stream checked against an expected-byte queue.
module tb_uart_rx_fifo;

    localparam int DIV = 8;
    localparam int DL  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          serial_rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [DL:0]   rx_count;
    logic          overrun;
    logic          framing_error;

    int            n_checks = 0;
    int            n_fails = 0;
    int            fe_cnt = 0;
    int            ovr_cnt = 0;
    bit            rnd_mode = 1'b0;
    bit            rnd_done = 1'b0;
    logic [7:0]    exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DIVISOR    (DIV),
        .DEPTH_LOG2 (DL)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .serial_rx     (serial_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .overrun       (overrun),
        .framing_error (framing_error)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // stop_low = 0 sends a good stop bit, else the stop is held low
    // for that many bit times and the line is released afterwards.
    task automatic send_frame(input logic [7:0] d, input int stop_low);
        serial_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            serial_rx = d[i];
            tick(DIV);
        end
        if (stop_low == 0) begin
            serial_rx = 1'b1;
            tick(DIV);
        end else begin
            serial_rx = 1'b0;
            tick(DIV * stop_low);
            serial_rx = 1'b1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!rx_valid && n < 200) begin
            tick(1);
            n++;
        end
        if (!rx_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic expect_pop(input string tag, input logic [7:0] exp);
        wait_valid(tag);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (framing_error) fe_cnt++;
        if (overrun) ovr_cnt++;
        if (framing_error && overrun) check("fe_ovr_excl", 1, 0);
        if (rnd_mode && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check("rnd_extra_pop", 1, 0);
            else check("rnd_data", rx_data, exp_q.pop_front());
        end
    end

    initial begin
        int fe0;
        int ov0;
        int exp_fe;
        int n;
        logic [7:0] b;

        tick(1);
        reset = 1'b1;
        tick(2);
        check("rst_valid", rx_valid, 0);
        check("rst_count", rx_count, 0);
        check("rst_ovr", overrun, 0);
        check("rst_fe", framing_error, 0);
        reset = 1'b0;
        tick(4);

        send_frame(8'hA5, 0);
        wait_valid("a5");
        check("a5_data", rx_data, 8'hA5);
        check("a5_count", rx_count, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("a5_pop_valid", rx_valid, 0);
        check("a5_pop_count", rx_count, 0);

        fe0 = fe_cnt;
        serial_rx = 1'b0;
        tick(3);
        serial_rx = 1'b1;
        tick(20);
        check("glitch_valid", rx_valid, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        send_frame(8'h3C, 0);
        expect_pop("glitch_next", 8'h3C);

        fe0 = fe_cnt;
        send_frame(8'h55, 2);
        tick(20);
        check("fe_once", fe_cnt - fe0, 1);
        check("fe_no_valid", rx_valid, 0);
        send_frame(8'h81, 0);
        expect_pop("fe_next", 8'h81);

        ov0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
        tick(20);
        check("ovr_count", rx_count, 4);
        check("ovr_pulse", ovr_cnt - ov0, 1);
        for (int i = 1; i <= 4; i++) expect_pop("ovr_pop", 8'(i));
        check("ovr_empty", rx_valid, 0);

        // Fifth byte becomes visible 79 cycles after its start edge
        // is driven, so the pop lands on the push edge.
        ov0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0);
        tick(20);
        check("sim_full", rx_count, 4);
        fork
            send_frame(8'h05, 0);
            begin
                tick(79);
                check("sim_head", rx_data, 8'h01);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(10);
        check("sim_count", rx_count, 4);
        check("sim_no_ovr", ovr_cnt - ov0, 0);
        for (int i = 2; i <= 5; i++) expect_pop("sim_pop", 8'(i));

        b = 8'($urandom_range(0, 255));
        send_frame(b, 0);
        tick(10);
        check("rst2_pre_count", rx_count, 1);
        serial_rx = 1'b0;
        tick(DIV);
        serial_rx = 1'b1;
        tick(DIV);
        serial_rx = 1'b0;
        tick(DIV);
        reset = 1'b1;
        tick(1);
        check("rst2_valid", rx_valid, 0);
        check("rst2_count", rx_count, 0);
        check("rst2_ovr", overrun, 0);
        check("rst2_fe", framing_error, 0);
        reset = 1'b0;
        serial_rx = 1'b1;
        tick(12 * DIV);
        check("rst2_nopartial", rx_valid, 0);
        send_frame(8'hC3, 0);
        expect_pop("rst2_c3", 8'hC3);
        tick(100);
        check("rst2_only", rx_valid, 0);

        fe0 = fe_cnt;
        ov0 = ovr_cnt;
        exp_fe = 0;
        rnd_mode = 1'b1;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    b = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 4) == 0) begin
                        send_frame(b, 1);
                        exp_fe++;
                        tick(DIV);
                    end else begin
                        exp_q.push_back(b);
                        send_frame(b, 0);
                    end
                    tick($urandom_range(0, 20));
                end
                tick(20);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rx_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        tick(2);
        rnd_mode = 1'b0;
        rx_ready = 1'b0;
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_fe", fe_cnt - fe0, exp_fe);
        check("rnd_no_ovr", ovr_cnt - ov0, 0);
        check("rnd_empty", rx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receiver for the SoC `serial_rx` pin; the receive-side counterpart of the SoC's 8N1 transmit path.
- Synchronises the asynchronous line, detects and validates frames, and writes received bytes into a small first-word-fall-through FIFO.
- The CPU-side register logic drains the FIFO with a valid/ready handshake.
- Sits between the top-level `serial_rxd` pad and the SoC peripheral bus.

Parameters:
- DIVISOR, 52, clock cycles per bit (6 MHz core clock / 115200 baud); must be >= 4.
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4 entries).

Ports:
- clk  input  1  core clock (single domain).
- reset  input  1  synchronous, active-high reset.
- serial_rx  input  1  asynchronous UART line; idle high.
- rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pops head on clk edge where rx_valid & rx_ready.
- rx_count  output  DEPTH_LOG2+1  current FIFO occupancy.
- overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0, except rx_data, which is don't-care with rx_valid=0. Synchroniser flops are set to 1. FSM goes to IDLE. FIFO is emptied. Reset wins over every other event, including mid-frame; a partial frame is discarded.
- Input sync: two-flop synchroniser on serial_rx. All decisions use the second flop (rx_s). This gives 2 cycles of latency from pin to FSM.
- Baud counter: counts DIVISOR-1 down to 0. It is reloaded on every state transition.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: stay while rx_s=1. On rx_s=0, go to START and load the counter with DIVISOR/2-1 (integer division) so the start bit is sampled at mid-bit.
- START: when the counter hits 0, sample rx_s.
  - rx_s=1: glitch; return to IDLE. No flags are raised.
  - rx_s=0: go to DATA with bit index 0 and counter DIVISOR-1.
- DATA: each time the counter hits 0, shift rx_s into a shift register LSB first and increment the bit index. After the 8th sample, go to STOP with counter DIVISOR-1.
- STOP: at the counter's 0, sample rx_s.
  - rx_s=1: issue a push request and go to IDLE. Back-to-back frames are therefore accepted with no extra idle time.
  - rx_s=0: pulse framing_error for 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. A break condition yields exactly one framing_error pulse.
- Latency: push request occurs at the mid-stop-bit sample. The byte is visible on rx_data/rx_valid on the next clock edge when the FIFO was empty, i.e. about 9.5 bit times plus 3 cycles after the falling start edge at the pin.
- FIFO: 2^DEPTH_LOG2 entries, circular read/write pointers, separate occupancy counter.
  - rx_valid = (count != 0).
  - rx_data = mem[rd_ptr], combinational from the register array.
  - Pointers wrap modulo depth.
- Push/pop rules:
  - pop = rx_valid & rx_ready.
  - push accepted if count < depth OR pop in the same cycle.
  - Simultaneous push and pop: count is unchanged, both pointers advance.
  - Pop when empty: ignored (rx_ready may be held high permanently).
  - Push when full without pop: byte dropped, overrun pulses 1 cycle, FIFO contents unchanged.
- framing_error and overrun never assert in the same cycle.
- rx_data must hold stable while rx_valid=1 and no pop occurs.

Test Plan (bench uses DIVISOR=8, DEPTH_LOG2=2):
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> exactly one push; rx_valid rises; rx_data=0xA5, rx_count=1; with rx_ready=1 for one cycle, rx_valid falls and rx_count=0.
- Low glitch of 3 cycles on an idle line -> no push, no framing_error; FSM back in IDLE; a following 0x3C frame is received correctly.
- Frame 0x55 with stop bit low for 2 bit times -> framing_error pulses exactly once, rx_valid stays 0; next frame 0x81 is received correctly.
- Five back-to-back frames 0x01..0x05 with rx_ready=0 -> rx_count saturates at 4, overrun pulses once on the 5th; pops then return 0x01,0x02,0x03,0x04 in order.
- FIFO full, rx_ready held 1 on the exact cycle the 5th byte pushes -> no overrun; rx_count stays 4; pop order 0x02,0x03,0x04,0x05.
- reset asserted for 1 cycle mid-DATA of a frame, line then driven idle and a 0xC3 frame sent -> no partial byte; outputs 0 during reset; 0xC3 is the only byte received.
